// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the clear sequencer state encoding and the default widths that
// decode and writeback also use.
package regfile_mp_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } seq_state_e;

endpackage

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port of the register file.
// It applies the enable, init and zero-register gating, and it optionally
// forwards same-cycle write data when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              init_done,
  input  logic [DATA_W-1:0] stored_data,
`ifdef REGFILE_BYPASS_EN
  input  logic              byp_we0,
  input  logic [ADDR_W-1:0] byp_waddr0,
  input  logic [DATA_W-1:0] byp_wdata0,
  input  logic              byp_we1,
  input  logic [ADDR_W-1:0] byp_waddr1,
  input  logic [DATA_W-1:0] byp_wdata1,
`endif
  output logic [DATA_W-1:0] rdata
);

  // Gate the stored value, then let lane 1 override lane 0 when bypassing
  always_comb begin
    rdata = '0;
    if (re && init_done && !((ZERO_REG != 0) && (raddr == '0))) begin
      rdata = stored_data;
`ifdef REGFILE_BYPASS_EN
      if (byp_we0 && (byp_waddr0 == raddr)) begin
        rdata = byp_wdata0;
      end
      if (byp_we1 && (byp_waddr1 == raddr)) begin
        rdata = byp_wdata1;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general purpose register file.
// It has NUM_RD combinational read ports and two synchronous write lanes.
// Storage is not reset, so a sequencer zeroes one entry per cycle after reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  seq_state_e        state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              init_done_q, init_done_d;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              lane0_we, lane1_we;

  assign init_done = init_done_q;

  // Next state of the clear sequencer: walk every entry once, then stay ready
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    clr_we      = 1'b0;
    clr_addr    = clr_cnt_q[ADDR_W-1:0];
    if (state_q == ST_CLEAR) begin
      clr_we    = 1'b1;
      clr_cnt_d = clr_cnt_q + CLR_ONE;
      if (clr_cnt_q == CLR_LAST) begin
        state_d     = ST_READY;
        init_done_d = 1'b1;
      end
    end
  end

  // Sequencer registers; reset restarts the clear pass from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Qualified lane write enables: only once ready and never to a hardwired zero entry
  always_comb begin
    lane0_we = we0 && init_done_q && !((ZERO_REG != 0) && (waddr0 == '0));
    lane1_we = we1 && init_done_q && !((ZERO_REG != 0) && (waddr1 == '0));
  end

  // Storage writes; lane 1 is applied last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end
      if (lane0_we) begin
        mem[waddr0] <= wdata0;
      end
      if (lane1_we) begin
        mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = raddr[i*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .re         (re[i]),
      .raddr      (port_addr),
      .init_done  (init_done_q),
      .stored_data(mem[port_addr]),
`ifdef REGFILE_BYPASS_EN
      .byp_we0    (lane0_we),
      .byp_waddr0 (waddr0),
      .byp_wdata0 (wdata0),
      .byp_we1    (lane1_we),
      .byp_waddr1 (waddr1),
      .byp_wdata1 (wdata1),
`endif
      .rdata      (rdata[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor of the core's GPR file: NUM_RD combinational read ports and two synchronous write ports.
- Storage array has no reset, so it can map to distributed RAM.
- After reset, a clear sequencer zeroes every entry one per cycle and then raises init_done.
- Sits between decode (read operands) and writeback (two retire lanes: ALU/mem and mul/div).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
init_done  out  1  high once clear sequence has completed
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
we0  in  1  write enable, lane 0
waddr0  in  ADDR_W  write address, lane 0
wdata0  in  DATA_W  write data, lane 0
we1  in  1  write enable, lane 1
waddr1  in  ADDR_W  write address, lane 1
wdata1  in  DATA_W  write data, lane 1

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Sequencer states: CLEAR, READY.
- rst=1 at a rising edge: state<=CLEAR, clr_cnt<=0, init_done<=0. Storage is untouched during rst-high cycles.
- CLEAR:
  - Each edge with rst=0 writes 0 to entry clr_cnt, then clr_cnt<=clr_cnt+1.
  - Edge that writes entry DEPTH-1: state<=READY, init_done<=1.
  - Clear therefore takes exactly DEPTH cycles after rst falls; init_done rises on that DEPTH-th edge.
  - clr_cnt is ADDR_W+1 bits wide, so there is no wrap ambiguity.
- rst asserted mid-CLEAR or in READY: sequence restarts from entry 0 after rst falls.
- While init_done=0: we0/we1 are ignored and all rdata are 0.
- READY writes:
  - On each edge, lane k writes wdata_k to entry waddr_k when we_k=1.
  - When ZERO_REG=1, writes to address 0 are dropped.
- Same-address collision (we0=we1=1, waddr0==waddr1): lane 1 wins, lane 0's data is discarded.
- Reads are combinational with zero-cycle latency. rdata[i] = 0 when any of the following hold:
  - re[i]=0
  - init_done=0
  - ZERO_REG=1 and raddr[i]==0
  - otherwise rdata[i] = stored entry, or the bypassed value (see Optional Feature).
- All ports are independent; any number of read ports may address the same entry.
- No X on rdata after init_done=1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose raddr matches an active write (we_k=1, init_done=1, and not address 0 when ZERO_REG=1) returns that write's wdata in the same cycle.
  - If both lanes match, lane 1 data is returned, consistent with the collision rule.
- Undefined: reads return the pre-edge stored value; new data is visible the cycle after the write.
- Clearing and reset behaviour are identical either way.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_CLEAR=1'b0, ST_READY=1'b1
  - default DATA_W/ADDR_W constants shared with decode/writeback
- Natural sub-module: regfile_rd_port, one instance per read port via generate.
  - Contains the zero/enable gating and the optional bypass mux.
- Sequencer and storage stay in the top.

Test Plan:
- Hold rst=1 for 3 cycles, release -> init_done stays 0 for 31 edges and rises on the 32nd (DEPTH=32). Every read issued before then returns 0x0, even with we0=1 waddr0=5 wdata0=0xDEADBEEF.
- After init, we0=1 waddr0=3 wdata0=0x12345678; next cycle re[0]=1 raddr=3 -> rdata[0]=0x12345678. Concurrent read of entry 4 returns 0x0.
- we0=1 waddr0=7 wdata0=0xAAAA0000 and we1=1 waddr1=7 wdata1=0x5555FFFF together -> following read of 7 returns 0x5555FFFF.
- we1=1 waddr1=0 wdata1=0xFFFFFFFF with ZERO_REG=1 -> read of 0 returns 0x0, both same cycle (bypass build) and next cycle.
- Same-cycle write of 0xCAFEF00D to entry 9 while reading 9:
  - with REGFILE_BYPASS_EN, rdata=0xCAFEF00D that cycle;
  - without it, rdata=previous value (0x0 after clear), then 0xCAFEF00D the next cycle.
- Write 0x11 to entry 2, assert rst during a later CLEAR pass at clr_cnt=10, release -> init_done low for another full DEPTH cycles, after which entry 2 reads 0x0.
